regfile_write_buffer: RTL
=========================

// Module: regfile_write_buffer
// PURPOSE
//  Write-back queue sitting directly upstream of the register file's write port.
//  Producers push (index, data) writes; the buffer drains them in order, at most one per cycle, onto one regfile write port.
//  A combinational lookup port returns the youngest pending value for an index. Readers therefore see writes that are queued but not yet in the array.
// PARAMETERS
//  width  32  data bits per register entry
//  n      5   register index bits (matches regfile index width)
//  depth  4   buffer entries; power of two, >= 2
// PORTS
//  clk            in   1      sole clock; all state updates on posedge
//  rst            in   1      reset; one clock; reset is synchronous and active-high
//  enq_valid      in   1      producer offers a write this cycle
//  enq_ready      out  1      buffer can accept; equals !full
//  enq_index      in   n      destination register of offered write
//  enq_data       in   width  value of offered write
//  drain_en       in   1      regfile port available this cycle (0 = stall drain)
//  rf_writeEn     out  1      write strobe to regfile port
//  rf_writeIndex  out  n      regfile write index (head entry)
//  rf_writeData   out  width  regfile write data (head entry)
//  lookup_index   in   n      register index being read by a consumer
//  lookup_hit     out  1      some pending entry targets lookup_index
//  lookup_data    out  width  data of youngest matching pending entry (0 if no hit)
//  count          out  log2(depth)+1  number of pending entries
// BEHAVIOUR
//  - Storage: circular array of depth entries {index, data}. head/tail pointers are log2(depth)+1 bits.
//    Wrap bit distinguishes full from empty. count = tail - head (mod 2^(log2(depth)+1)).
//  - empty = (count==0); full = (count==depth); enq_ready = !full (combinational, no enq-side bypass).
//  - Enqueue fires on enq_valid && enq_ready: entry written at tail, tail+1 at posedge.
//    enq_valid while full is ignored and the entry is dropped; the producer must hold it.
//  - Drain: rf_writeEn = !empty && drain_en && !rst (combinational).
//    rf_writeIndex/rf_writeData = head entry whenever !empty, else 0. head+1 at posedge when rf_writeEn.
//  - Latency: a write enqueued at cycle t appears on the rf port no earlier than cycle t+1. No same-cycle pass-through.
//  - Simultaneous enq+drain:
//    - count unchanged.
//    - When full, enq_ready is still 0 that cycle. Slot frees next cycle.
//  - Ordering: strict FIFO. Duplicate indices are not coalesced; each reaches the regfile in order, last one wins.
//  - Lookup (combinational):
//    - Scan all valid entries, including the head being drained this cycle. The regfile commits at the edge.
//    - Select the youngest (closest to tail) entry whose index == lookup_index.
//    - A same-cycle enqueue is NOT visible to lookup.
//  - Pointer wrap: tail/head wrap modulo 2*depth. Entries are reused without clearing.
//    Validity is derived only from the head..tail range.
//  - Reset (rst=1 at posedge): head=tail=0, count=0.
//    All pending writes are discarded and never reach the regfile.
//    While rst=1: rf_writeEn=0, enq_ready=0, lookup_hit=0, lookup_data=0.
//    Reset mid-operation behaves identically; there is no partial drain.
//  - Array contents need no reset; outputs never expose an invalid entry.
// TESTING
//  1 Reset then idle: rst=1 for 2 cycles, release -> count=0, enq_ready=1, rf_writeEn=0, lookup_hit=0.
//  2 Single write: enq (idx 3, 0xDEADBEEF) at cycle t, drain_en=1
//    -> cycle t+1: rf_writeEn=1, rf_writeIndex=3, rf_writeData=0xDEADBEEF; cycle t+2: count=0.
//  3 Fill/stall: drain_en=0, enq 4 writes (idx 1..4) -> count=4, enq_ready=0.
//    5th enq is ignored. Raise drain_en -> idx 1,2,3,4 emitted on 4 consecutive cycles.
//  4 Bypass priority: drain_en=0, enq (5,0x11) then (5,0x22); lookup_index=5
//    -> hit=1, data=0x22. After both drain -> hit=0, data=0.
//  5 Concurrent + wrap: drain_en=1, enq every cycle for 12 cycles with idx=i, data=i*16
//    -> count stays 1 after first cycle; rf sees idx 0..11 in order across pointer wrap.
//  6 Reset mid-flight: 3 entries pending, assert rst one cycle
//    -> rf_writeEn=0 that cycle, count=0 after; lookup for queued idx misses.

Source files
------------

// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - in-order write-back queue in front of a regfile write port, with youngest-match lookup
module regfile_write_buffer #(
    parameter int width = 32,
    parameter int n     = 5,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [n-1:0]             enq_index,
    input  logic [width-1:0]         enq_data,
    input  logic                     drain_en,
    output logic                     rf_writeEn,
    output logic [n-1:0]             rf_writeIndex,
    output logic [width-1:0]         rf_writeData,
    input  logic [n-1:0]             lookup_index,
    output logic                     lookup_hit,
    output logic [width-1:0]         lookup_data,
    output logic [$clog2(depth):0]   count
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_count = (aw+1)'(depth);

    logic [aw:0]        head_q, head_d;
    logic [aw:0]        tail_q, tail_d;
    logic [n-1:0]       idx_q  [depth];
    logic [width-1:0]   data_q [depth];

    logic [aw:0]        count_w;
    logic               empty;
    logic               full;
    logic               enq_fire;
    logic [aw-1:0]      head_slot;
    logic [aw-1:0]      tail_slot;

    assign count_w   = tail_q - head_q;
    assign empty     = (count_w == '0);
    assign full      = (count_w == full_count);
    assign head_slot = head_q[aw-1:0];
    assign tail_slot = tail_q[aw-1:0];

    assign enq_ready  = !full && !rst;
    assign enq_fire   = enq_valid && enq_ready;
    assign rf_writeEn = !empty && drain_en && !rst;
    assign count      = count_w;

    always_comb begin
        rf_writeIndex = '0;
        rf_writeData  = '0;
        if (!empty) begin
            rf_writeIndex = idx_q[head_slot];
            rf_writeData  = data_q[head_slot];
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (rf_writeEn) head_d = head_q + 1'b1;
        if (enq_fire)   tail_d = tail_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is never cleared; validity comes solely from the head..tail window.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            idx_q[tail_slot]  <= enq_index;
            data_q[tail_slot] <= enq_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest pending write.
    logic [aw-1:0] scan_slot;
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        scan_slot   = '0;
        for (int i = 0; i < depth; i++) begin
            scan_slot = head_slot + aw'(i);
            if (!rst && ((aw+1)'(i) < count_w) && (idx_q[scan_slot] == lookup_index)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[scan_slot];
            end
        end
    end
endmodule
